if_fetch_stage: RTL and testbench

//  Instruction-fetch front end feeding the IF/ID boundary of top_pipelining.
//  - Owns the PC and issues one word request per cycle to a synchronous instruction memory (1-cycle read latency).
//  - Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
//  - Accepts branch/jump redirects from EX, which flush all fetched and in-flight instructions.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/if_fetch_stage.sv | 93 +++++++++
 tb/tb_if_fetch_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x fetch_pkt_t, registered head, synchronous flush.
// Zero-latency head view; caller must not push when full or pop when empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_pkt_t    push_dat_i,
    input  logic          pop_i,
    output fetch_pkt_t    head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_pkt_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // Empty buffer shows a NOP at pc 0 so decode never sees stale words.
    always_comb begin
        head_dat_o.instr = NOP_INSTR;
        head_dat_o.pc    = '0;
        if (!empty_o) head_dat_o = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch front end: owns PC, one request/cycle to 1-cycle imem, words to decode ~2 cycles after request.
// Requests are throttled so buffered + in-flight words never exceed DEPTH; a redirect flushes everything.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;

    logic            pop, push;
    logic [CW:0]     occ;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    fetch_pkt_t      push_pkt, head_pkt;

    assign pop      = id_valid && id_ready;
    assign push     = inflight_q && !kill_q;
    assign push_pkt = '{instr: imem_rdata, pc: tag_pc_q};
    assign occ      = {1'b0, fifo_count} + (CW+1)'(inflight_q);

    // Gating with rst keeps the bus quiet while reset is held.
    assign imem_req  = rst && !redirect_valid && (occ < (CW+1)'(DEPTH) + (CW+1)'(pop));
    assign imem_addr = pc_q;

    always_comb begin
        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = imem_req;
        kill_d     = redirect_valid;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (imem_req) begin
            pc_d     = pc_q + XLEN'(4);
            tag_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_pkt),
        .pop_i      (pop),
        .head_dat_o (head_pkt),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign id_valid = !fifo_empty;
    assign id_instr = head_pkt.instr;
    assign id_pc    = head_pkt.pc;

    // Offset bits of the target are dropped; full is implied by the occupancy check.
    logic unused_ok;
    assign unused_ok = ^{redirect_pc[1:0], fifo_full};

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a 1-cycle imem returning addr>>2.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr >> 2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic see(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_vld"}, {31'b0, id_valid}, {31'b0, v});
        if (v) begin
            chk({tag, "_pc"}, id_pc, pc);
            chk({tag, "_ins"}, id_instr, pc >> 2);
        end
    endtask

    task automatic req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, r});
        if (r) chk({tag, "_addr"}, imem_addr, a);
    endtask

    initial begin
        rst            = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // 1: reset, then streaming
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_vld", {31'b0, id_valid}, 32'h0);
        chk("rst_ins", id_instr, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);
        rst = 1'b1;
        #1;
        req("c0", 1, 32'h0);
        step(1, 0, 0); req("c1", 1, 32'h4); see("c1", 0, 0);
        step(1, 0, 0); see("c2", 1, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 0);
            see("stream", 1, 32'(4 * k));
            req("stream", 1, 32'(4 * k + 8));
        end

        // 2: decode stall
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0);
            see("stall", 1, 32'h18);
            req("stall", 0, 0);
        end
        step(1, 0, 0); see("resume0", 1, 32'h18); req("resume0", 1, 32'h20);
        step(1, 0, 0); see("resume1", 1, 32'h1C);
        step(1, 0, 0); see("resume2", 1, 32'h20);
        step(1, 0, 0); see("resume3", 1, 32'h24);

        // 3: redirect with a request in flight
        step(1, 1, 32'h100); req("redir_r", 0, 0);
        step(1, 0, 0); see("redir_r1", 0, 0); req("redir_r1", 1, 32'h100);
        step(1, 0, 0); see("redir_r2", 0, 0); req("redir_r2", 1, 32'h104);
        step(1, 0, 0); see("redir_r3", 1, 32'h100);
        step(1, 0, 0); see("redir_r4", 1, 32'h104);

        // 4: unaligned target, then back-to-back redirects
        step(1, 1, 32'h203); req("unal_r", 0, 0);
        step(1, 0, 0); req("unal_r1", 1, 32'h200); see("unal_r1", 0, 0);
        step(1, 0, 0); see("unal_r2", 0, 0);
        step(1, 0, 0); see("unal_r3", 1, 32'h200);
        step(1, 1, 32'h300);
        step(1, 1, 32'h400); req("b2b_r", 0, 0);
        step(1, 0, 0); req("b2b_r1", 1, 32'h400); see("b2b_r1", 0, 0);
        step(1, 0, 0); see("b2b_r2", 0, 0);
        step(1, 0, 0); see("b2b_r3", 1, 32'h400);
        step(1, 0, 0); see("b2b_r4", 1, 32'h404);

        // 5: PC wrap
        step(1, 1, 32'hFFFF_FFF8);
        step(1, 0, 0); req("wrap1", 1, 32'hFFFF_FFF8);
        step(1, 0, 0); req("wrap2", 1, 32'hFFFF_FFFC);
        step(1, 0, 0); see("wrap3", 1, 32'hFFFF_FFF8); req("wrap3", 1, 32'h0);
        step(1, 0, 0); see("wrap4", 1, 32'hFFFF_FFFC);
        step(1, 0, 0); see("wrap5", 1, 32'h0);
        step(1, 0, 0); see("wrap6", 1, 32'h4);

        // redirect while stalled with a full buffer
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        req("full", 0, 0); see("full", 1, 32'h8);
        step(0, 1, 32'h500); req("full_r", 0, 0);
        step(0, 0, 0); see("full_r1", 0, 0); req("full_r1", 1, 32'h500);
        step(0, 0, 0); see("full_r2", 0, 0);
        step(0, 0, 0); see("full_r3", 1, 32'h500);
        step(0, 0, 0); see("full_r4", 1, 32'h500);
        step(1, 0, 0); see("full_r5", 1, 32'h500);
        step(1, 0, 0); see("full_r6", 1, 32'h504);
        step(1, 0, 0); see("full_r7", 1, 32'h508);

        // 6: reset mid-stream
        step(1, 0, 0);
        rst = 1'b0;
        #1;
        req("mrst0", 0, 0);
        step(1, 0, 0);
        see("mrst1", 0, 0); req("mrst1", 0, 0);
        chk("mrst1_addr", imem_addr, 32'h0);
        chk("mrst1_ins", id_instr, 32'h0000_0013);
        rst = 1'b1;
        #1;
        req("mrel0", 1, 32'h0);
        step(1, 0, 0); see("mrel1", 0, 0);
        step(1, 0, 0); see("mrel2", 1, 32'h0);
        step(1, 0, 0); see("mrel3", 1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
